// File: rtl/gstmcu_pkg.sv
// Shared MCU definitions: DMA-sound register map, ctrl bit positions, frame FSM states
// and the byte layout used to read a 21-bit word address back through 8-bit registers.
package gstmcu_pkg;

   localparam int SND_AW = 21;

   localparam logic [3:0] SND_CTRL    = 4'd0;
   localparam logic [3:0] SND_START_H = 4'd1;
   localparam logic [3:0] SND_START_M = 4'd2;
   localparam logic [3:0] SND_START_L = 4'd3;
   localparam logic [3:0] SND_CNT_H   = 4'd4;
   localparam logic [3:0] SND_CNT_M   = 4'd5;
   localparam logic [3:0] SND_CNT_L   = 4'd6;
   localparam logic [3:0] SND_END_H   = 4'd7;
   localparam logic [3:0] SND_END_M   = 4'd8;
   localparam logic [3:0] SND_END_L   = 4'd9;

   localparam int SND_PLAY = 0;
   localparam int SND_RPT  = 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } snd_state_t;

   typedef enum logic [1:0] {
      BYTE_H = 2'd0,
      BYTE_M = 2'd1,
      BYTE_L = 2'd2
   } snd_byte_t;

   // Word address bits 21:1 as seen through the byte registers: high byte carries
   // addr[21:16] with bits 7:6 zero, low byte carries addr[7:1] with bit 0 zero.
   function automatic logic [7:0] snd_addr_byte(input logic [SND_AW-1:0] a,
                                                input snd_byte_t b);
      logic [7:0] r;
      r = '0;
      case (b)
         BYTE_H:  r = {2'b00, a[20:15]};
         BYTE_M:  r = a[14:7];
         BYTE_L:  r = {a[6:0], 1'b0};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snd_addr_reg.sv
// Three-byte-writable 21-bit sound word-address register with byte readback;
// used for both the frame-start and frame-end shadow registers.
module snd_addr_reg
   import gstmcu_pkg::*;
#(
   parameter int AW = SND_AW
) (
   input  logic          clk32,
   input  logic          reset,
   input  logic          we,
   input  snd_byte_t     bsel,
   input  logic [7:0]    din,
   output logic [AW-1:0] addr,
   output logic [7:0]    rdata
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
         addr <= '0;
      end else if (we) begin
         case (bsel)
            BYTE_H:  addr[AW-1:15] <= din[AW-16:0];
            BYTE_M:  addr[14:7]    <= din;
            BYTE_L:  addr[6:0]     <= din[7:1];
            default: ;
         endcase
      end
   end

   assign rdata = snd_addr_byte(addr, bsel);

endmodule

// File: rtl/snd_frame_ctl.sv
// STE DMA-sound frame controller: ctrl/start/end/counter registers, frame FSM and
// the sound word address driven to the MCU address mux during sound cycles.
module snd_frame_ctl
   import gstmcu_pkg::*;
#(
   parameter int AW = SND_AW
) (
   input  logic          clk32,
   input  logic          reset,
   input  logic          reg_we,
   input  logic [3:0]    reg_a,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   input  logic          snd_fetch,
   output logic [AW-1:0] snd,
   output logic          sndon,
   output logic          stoff,
   output logic          sint,
   output logic          frame_end
);

   snd_state_t    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [AW-1:0] act_end_q, act_end_d;
   logic          play_q, play_d;
   logic          rpt_q, rpt_d;
   logic          pend_q, pend_d;
   logic          fe_q, fe_d;
   logic          stoff_q, stoff_d;
   logic          term;

   logic          ctrl_we, start_sel, cnt_sel, end_sel;
   logic [AW-1:0] start_addr, end_addr;
   logic [7:0]    start_rd, end_rd;
   snd_byte_t     start_bsel, cnt_bsel, end_bsel;

   assign ctrl_we   = reg_we && (reg_a == SND_CTRL);
   assign start_sel = (reg_a >= SND_START_H) && (reg_a <= SND_START_L);
   assign cnt_sel   = (reg_a >= SND_CNT_H)   && (reg_a <= SND_CNT_L);
   assign end_sel   = (reg_a >= SND_END_H)   && (reg_a <= SND_END_L);

   assign start_bsel = snd_byte_t'(2'(reg_a - SND_START_H));
   assign cnt_bsel   = snd_byte_t'(2'(reg_a - SND_CNT_H));
   assign end_bsel   = snd_byte_t'(2'(reg_a - SND_END_H));

   snd_addr_reg #(.AW(AW)) u_start (
      .clk32 (clk32),
      .reset (reset),
      .we    (reg_we && start_sel),
      .bsel  (start_bsel),
      .din   (din),
      .addr  (start_addr),
      .rdata (start_rd)
   );

   snd_addr_reg #(.AW(AW)) u_end (
      .clk32 (clk32),
      .reset (reset),
      .we    (reg_we && end_sel),
      .bsel  (end_bsel),
      .din   (din),
      .addr  (end_addr),
      .rdata (end_rd)
   );

   assign cnt_inc = cnt_q + AW'(1);

   // NOTE: every signal written here gets its default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_end_d = act_end_q;
      play_d    = play_q;
      rpt_d     = rpt_q;
      pend_d    = 1'b0;
      fe_d      = 1'b0;
      stoff_d   = 1'b0;
      term      = 1'b0;

      if (ctrl_we) begin
         play_d = din[SND_PLAY];
         rpt_d  = din[SND_RPT];
      end

      case (state_q)
         IDLE: begin
            if (ctrl_we && din[SND_PLAY]) begin
               state_d   = RUN;
               cnt_d     = start_addr;
               act_end_d = end_addr;
               pend_d    = (start_addr == end_addr);
            end
         end
         RUN: begin
            if (ctrl_we && !din[SND_PLAY]) begin
               state_d = IDLE;
            end else begin
               // An empty frame terminates on its first RUN cycle without a fetch.
               if (pend_q) begin
                  term = 1'b1;
               end else if (snd_fetch) begin
                  cnt_d = cnt_inc;
                  term  = (cnt_inc == act_end_q);
               end
               if (term) begin
                  fe_d = 1'b1;
                  if (rpt_d) begin
                     cnt_d     = start_addr;
                     act_end_d = end_addr;
                     pend_d    = (start_addr == end_addr);
                  end else begin
                     play_d  = 1'b0;
                     stoff_d = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         act_end_q <= '0;
         play_q    <= 1'b0;
         rpt_q     <= 1'b0;
         pend_q    <= 1'b0;
         fe_q      <= 1'b0;
         stoff_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         act_end_q <= act_end_d;
         play_q    <= play_d;
         rpt_q     <= rpt_d;
         pend_q    <= pend_d;
         fe_q      <= fe_d;
         stoff_q   <= stoff_d;
      end
   end

   always_comb begin
      dout = '0;
      if (reg_a == SND_CTRL) begin
         dout = {6'b0, rpt_q, play_q};
      end else if (start_sel) begin
         dout = start_rd;
      end else if (cnt_sel) begin
         dout = snd_addr_byte(cnt_q, cnt_bsel);
      end else if (end_sel) begin
         dout = end_rd;
      end
   end

   assign snd       = cnt_q;
   assign sndon     = play_q;
   assign stoff     = stoff_q;
   assign frame_end = fe_q;
   // The MFP sees the frame boundary as a one-cycle low on a repeat reload.
   assign sint      = (state_q == RUN) && !fe_q;

endmodule

// File: tb/tb_snd_frame_ctl.sv
// Bench for snd_frame_ctl: directed frame scenarios plus randomized frames, each cycle
// compared against a register-map / frame-rule reference model.
module tb_snd_frame_ctl;

   localparam int AW  = 21;
   localparam int MOD = 1 << AW;

   localparam int A_CTRL  = 0;
   localparam int A_START = 1;
   localparam int A_END   = 7;

   logic          clk32 = 1'b0;
   logic          reset;
   logic          reg_we;
   logic [3:0]    reg_a;
   logic [7:0]    din;
   logic [7:0]    dout;
   logic          snd_fetch;
   logic [AW-1:0] snd;
   logic          sndon;
   logic          stoff;
   logic          sint;
   logic          frame_end;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: shadow start/end, active end, counter, flags.
   int m_start, m_end, m_act, m_cnt;
   bit m_run, m_play, m_rpt, m_pend;
   bit e_fe, e_so;

   always #5 clk32 = ~clk32;

   snd_frame_ctl #(.AW(AW)) dut (
      .clk32     (clk32),
      .reset     (reset),
      .reg_we    (reg_we),
      .reg_a     (reg_a),
      .din       (din),
      .dout      (dout),
      .snd_fetch (snd_fetch),
      .snd       (snd),
      .sndon     (sndon),
      .stoff     (stoff),
      .sint      (sint),
      .frame_end (frame_end)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Byte view of a word address: byte address = 2 * word address.
   function automatic int get_byte(input int v, input int sel);
      int ba;
      ba = v * 2;
      case (sel)
         0:       return (ba >> 16) & 'h3F;
         1:       return (ba >> 8) & 'hFF;
         default: return ba & 'hFE;
      endcase
   endfunction

   function automatic int put_byte(input int v, input int sel, input int d);
      int ba;
      ba = v * 2;
      case (sel)
         0:       ba = (ba & 'h00FFFF) | ((d & 'h3F) << 16);
         1:       ba = (ba & 'h3F00FF) | ((d & 'hFF) << 8);
         default: ba = (ba & 'h3FFF00) | (d & 'hFE);
      endcase
      return ba / 2;
   endfunction

   function automatic int exp_dout(input int a);
      if (a == 0)      return int'(m_rpt) * 2 + int'(m_play);
      else if (a <= 3) return get_byte(m_start, a - 1);
      else if (a <= 6) return get_byte(m_cnt, a - 4);
      else if (a <= 9) return get_byte(m_end, a - 7);
      return 0;
   endfunction

   task automatic model_reset();
      m_start = 0; m_end = 0; m_act = 0; m_cnt = 0;
      m_run = 0; m_play = 0; m_rpt = 0; m_pend = 0;
      e_fe = 0; e_so = 0;
   endtask

   // One clock of the frame rules, applied to the inputs held during that cycle.
   task automatic model_cycle(input bit we, input int a, input logic [7:0] d, input bit f);
      bit ctrl, hit;
      ctrl = we && (a == A_CTRL);
      hit  = 0;
      e_fe = 0;
      e_so = 0;
      if (ctrl) begin
         m_play = d[0];
         m_rpt  = d[1];
      end
      if (!m_run) begin
         if (ctrl && d[0]) begin
            m_run  = 1;
            m_cnt  = m_start;
            m_act  = m_end;
            m_pend = (m_start == m_end);
         end
      end else if (ctrl && !d[0]) begin
         m_run  = 0;
         m_pend = 0;
      end else begin
         if (m_pend) hit = 1;
         else if (f) begin
            m_cnt = (m_cnt + 1) % MOD;
            hit   = (m_cnt == m_act);
         end
         m_pend = 0;
         if (hit) begin
            e_fe = 1;
            if (m_rpt) begin
               m_cnt  = m_start;
               m_act  = m_end;
               m_pend = (m_start == m_end);
            end else begin
               m_run  = 0;
               m_play = 0;
               e_so   = 1;
            end
         end
      end
      // Shadow writes land after any reload of this cycle used the old values.
      if (we && a >= 1 && a <= 3) m_start = put_byte(m_start, a - 1, int'(d));
      if (we && a >= 7 && a <= 9) m_end   = put_byte(m_end, a - 7, int'(d));
   endtask

   task automatic check_outputs();
      check("snd", 32'(snd), m_cnt);
      check("sndon", 32'(sndon), 32'(m_play));
      check("stoff", 32'(stoff), 32'(e_so));
      check("sint", 32'(sint), 32'(m_run && !e_fe));
      check("frame_end", 32'(frame_end), 32'(e_fe));
      check($sformatf("dout[%0d]", reg_a), 32'(dout), exp_dout(int'(reg_a)));
   endtask

   // Drive one cycle from a falling edge, then compare at the next falling edge.
   task automatic step(input bit we, input int a, input logic [7:0] d, input bit f);
      reg_we    = we;
      reg_a     = 4'(a);
      din       = d;
      snd_fetch = f;
      @(negedge clk32);
      model_cycle(we, a, d, f);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, $urandom_range(0, 15), 8'($urandom), 0);
   endtask

   task automatic fetches(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         step(0, $urandom_range(0, 15), 8'($urandom), 1);
         idle($urandom_range(0, gap));
      end
   endtask

   // Write a word address through its three byte registers, with junk in ignored bits.
   task automatic wr_addr(input int base, input int v);
      step(1, base,     8'(get_byte(v, 0) | ($urandom_range(0, 3) << 6)), 0);
      step(1, base + 1, 8'(get_byte(v, 1)), 0);
      step(1, base + 2, 8'(get_byte(v, 2) | $urandom_range(0, 1)), 0);
   endtask

   task automatic wr_ctrl(input logic [7:0] d);
      step(1, A_CTRL, d, 0);
   endtask

   initial begin
      int s, e, r;
      reset = 1'b1; reg_we = 1'b0; reg_a = '0; din = '0; snd_fetch = 1'b0;
      model_reset();
      #2;
      check_outputs();
      @(negedge clk32);
      reset = 1'b0;
      idle(3);

      // Single frame, no repeat: stop with stoff on the 4th fetch.
      wr_addr(A_START, 'h010000);
      wr_addr(A_END, 'h010004);
      wr_ctrl(8'h01);
      fetches(4, 8);
      idle(2);

      // Repeat mode over three frames.
      wr_ctrl(8'h03);
      fetches(12, 8);
      wr_ctrl(8'h00);

      // End rewritten mid-frame: current frame keeps the old end.
      wr_addr(A_START, 'h01FFFA);
      wr_addr(A_END, 'h01FFFE);
      wr_ctrl(8'h03);
      fetches(2, 3);
      wr_addr(A_END, 'h020000);
      fetches(14, 3);
      wr_ctrl(8'h00);

      // Start rewritten on the cycle of a reload: reload uses the old start.
      wr_addr(A_START, 'h000200);
      wr_addr(A_END, 'h000202);
      wr_ctrl(8'h03);
      fetches(1, 2);
      step(1, A_START + 2, 8'h10, 1);
      fetches(3, 2);
      wr_ctrl(8'h00);

      // Wrap through 1FFFFF -> 000000.
      wr_addr(A_START, 'h1FFFFE);
      wr_addr(A_END, 'h000001);
      wr_ctrl(8'h01);
      fetches(3, 4);
      idle(2);

      // Empty frame, then ctrl=00 colliding with a fetch.
      wr_addr(A_START, 'h000100);
      wr_addr(A_END, 'h000100);
      wr_ctrl(8'h01);
      idle(3);
      wr_addr(A_END, 'h000104);
      wr_ctrl(8'h01);
      fetches(1, 2);
      step(1, A_CTRL, 8'h00, 1);
      idle(2);

      // Randomized short frames with stray register writes and back-to-back fetches.
      for (int k = 0; k < 20; k++) begin
         s = $urandom_range(0, MOD - 1);
         e = (s + $urandom_range(0, 6)) % MOD;
         wr_addr(A_START, s);
         wr_addr(A_END, e);
         wr_ctrl({6'($urandom), 1'($urandom), 1'b1});
         for (int j = 0; j < 40; j++) begin
            r = $urandom_range(0, 15);
            if (r < 5)       step(0, $urandom_range(0, 15), 8'($urandom), 1);
            else if (r < 7)  step(1, $urandom_range(1, 15), 8'($urandom), 1'($urandom));
            else if (r == 7) step(1, A_CTRL, {6'($urandom), 1'($urandom), 1'b1}, 1'($urandom));
            else             step(0, $urandom_range(0, 15), 8'($urandom), 0);
         end
         wr_ctrl(8'h00);
      end

      // Reset in the middle of a running frame.
      wr_addr(A_START, 'h0ABCDE);
      wr_addr(A_END, 'h0ABCE8);
      wr_ctrl(8'h03);
      fetches(3, 2);
      reset = 1'b1; reg_we = 1'b0; snd_fetch = 1'b0;
      model_reset();
      #1;
      for (int a = 0; a < 10; a++) begin
         reg_a = 4'(a);
         #1;
         check_outputs();
      end
      @(negedge clk32);
      reset = 1'b0;
      idle(2);
      wr_addr(A_START, 'h000055);
      wr_addr(A_END, 'h000057);
      wr_ctrl(8'h01);
      fetches(2, 2);
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
